div: RTL and testbench
======================

DIV -- requirements
Module: div

Interface
REQ-001 Parameter DW, default 32, operand width in bits; the result width is 2*DW.
REQ-002 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 Port resetn, input, 1, reset; asynchronous, active-low.
REQ-004 Port flush, input, 1, pipeline flush request.
REQ-005 Port flush_cause, input, 1, flush reason; 1 = exception.
REQ-006 Port start, input, 1, request to begin a division.
REQ-007 Port s, input, 1, signedness; 1 = signed, 0 = unsigned.
REQ-008 Port x, input, DW, dividend.
REQ-009 Port y, input, DW, divisor.
REQ-010 Port z, output, 2*DW, result; z = {remainder, quotient} (HI/LO order).
REQ-011 Port ready, output, 1, result-valid strobe.
REQ-012 Port busy, output, 1, high while a division is in progress.

Function
REQ-013 The FSM SHALL have four states: FREE, BYZERO, ON and END.
REQ-014 In FREE, start=1 SHALL latch x, y and s; the next state SHALL be BYZERO if y==0, otherwise ON.
REQ-015 ON SHALL perform one radix-2 restoring step per cycle on operand magnitudes, for exactly DW cycles, counted by a counter cleared on entry.
REQ-016 After the DW-th ON cycle the FSM SHALL enter END; BYZERO SHALL enter END after 1 cycle.
REQ-017 In END, ready SHALL be 1 for exactly one cycle and z SHALL carry the result; the next state SHALL be FREE.
REQ-018 Latency from the start-sampling edge to ready high SHALL be DW+1 cycles when y!=0 and 2 cycles when y==0.
REQ-019 Signed mode: quotient SHALL be negated if sign(x)!=sign(y); remainder SHALL take the sign of x; truncation SHALL be toward zero.
REQ-020 Signed -2^(DW-1) / -1 SHALL return quotient 0x80000000 and remainder 0, with no flag.
REQ-021 Divide-by-zero SHALL return z = 0.
REQ-022 busy SHALL be 1 in BYZERO and ON, and 0 in FREE and END.
REQ-023 start SHALL be ignored outside FREE; operand changes after latching SHALL have no effect.
REQ-024 flush==1 && flush_cause==1 in any state SHALL force FREE at the next edge, with ready held 0 and no result produced.
REQ-025 If that flush coincides with start in FREE, the flush SHALL win and the request SHALL be dropped.
REQ-026 A flush with flush_cause==0 SHALL NOT affect the block.
REQ-027 z SHALL hold its last result until the next END; ready and busy SHALL drive no X in any state.

Reset
REQ-028 resetn==0 SHALL immediately force FREE, clear the counter and operand registers, and drive z=0, ready=0, busy=0.
REQ-029 Reset mid-division SHALL discard the operation; after reset release, the first start SHALL behave as a fresh request.

Structure
REQ-030 The shared defines file SHALL hold RstEnable, Flush, Exception, ZeroWord and the state encodings DivFree, DivByZero, DivOn and DivEnd.
REQ-031 The block SHALL be a single module with no sub-module.
REQ-032 The per-step trial subtraction SHALL be one DW+1-bit subtract inside the ON datapath, registered each cycle with no multi-cycle path.

Verification
REQ-033 Unsigned: s=0, x=100, y=7 -> ready 33 cycles after start, z=0x00000002_0000000E.
REQ-034 Signed: s=1, x=0xFFFFFFF9 (-7), y=2 -> z=0xFFFFFFFF_FFFFFFFD.
REQ-035 Signed overflow: s=1, x=0x80000000, y=0xFFFFFFFF -> z=0x00000000_80000000.
REQ-036 Divide-by-zero: x=5, y=0 -> ready 2 cycles after start, z=0; busy high for exactly 1 cycle.
REQ-037 Exception flush: flush=1 with flush_cause=1 on ON cycle 10 -> busy=0 next cycle and ready never asserts; a following start with x=9, y=3 -> z=0x00000000_00000003.
REQ-038 Reset and ignored start: resetn low on ON cycle 5 -> z=0 and busy=0 at once; start pulses during busy are ignored (one ready per accepted start).

Source files
------------

// File: rtl/div_pkg.sv
// Shared defines for the divider: reset/flush polarities, zero word and the
// FSM state encodings kept bit-compatible with the legacy defines file.
package div_pkg;

    localparam logic        RstEnable = 1'b0;
    localparam logic        Flush     = 1'b1;
    localparam logic        Exception = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

endpackage

// File: rtl/div.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, DW cycles per op.
// z = {remainder, quotient}; ready pulses one cycle as END hands back to FREE.
module div #(
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            flush_cause,
    input  logic            start,
    input  logic            s,
    input  logic [DW-1:0]   x,
    input  logic [DW-1:0]   y,
    output logic [2*DW-1:0] z,
    output logic            ready,
    output logic            busy
);
    import div_pkg::*;

    localparam int CW = $clog2(DW) + 1;

    logic [1:0]      state;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   dmag;
    logic [DW-1:0]   rem;
    logic [DW-1:0]   quo;
    logic            neg_q;
    logic            neg_r;
    logic [2*DW-1:0] z_q;
    logic            ready_q;

    logic [DW:0]     partial;
    logic [DW:0]     trial;
    logic            fits;
    logic [DW-1:0]   rem_nx;
    logic [DW-1:0]   quo_nx;
    logic [DW-1:0]   q_out;
    logic [DW-1:0]   r_out;
    logic [DW-1:0]   x_mag;
    logic [DW-1:0]   y_mag;
    logic            kill;

    // One restoring step: the dividend shifts out of quo into the remainder.
    always_comb begin
        partial = {rem, quo[DW-1]};
        trial   = partial - {1'b0, dmag};
        fits    = ~trial[DW];
        rem_nx  = fits ? trial[DW-1:0] : partial[DW-1:0];
        quo_nx  = {quo[DW-2:0], fits};
        q_out   = neg_q ? -quo : quo;
        r_out   = neg_r ? -rem : rem;
        x_mag   = (s && x[DW-1]) ? -x : x;
        y_mag   = (s && y[DW-1]) ? -y : y;
        kill    = (flush == Flush) && (flush_cause == Exception);
    end

    // Divide-by-zero loads zero operands so END naturally yields z = 0.
    always_ff @(posedge clk or negedge resetn) begin
        if (resetn == RstEnable) begin
            state   <= DivFree;
            cnt     <= '0;
            dmag    <= '0;
            rem     <= '0;
            quo     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            z_q     <= '0;
            ready_q <= 1'b0;
        end else if (kill) begin
            state   <= DivFree;
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            case (state)
                DivFree: begin
                    if (start) begin
                        cnt <= '0;
                        if (y == '0) begin
                            dmag  <= '0;
                            rem   <= '0;
                            quo   <= '0;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            state <= DivByZero;
                        end else begin
                            dmag  <= y_mag;
                            rem   <= '0;
                            quo   <= x_mag;
                            neg_q <= s & (x[DW-1] ^ y[DW-1]);
                            neg_r <= s & x[DW-1];
                            state <= DivOn;
                        end
                    end
                end
                DivByZero: begin
                    state <= DivEnd;
                end
                DivOn: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    if (cnt == CW'(DW - 1)) begin
                        state <= DivEnd;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DivEnd: begin
                    z_q     <= {r_out, q_out};
                    ready_q <= 1'b1;
                    state   <= DivFree;
                end
                default: begin
                    state <= DivFree;
                end
            endcase
        end
    end

    assign z     = z_q;
    assign ready = ready_q;
    assign busy  = (state == DivByZero) || (state == DivOn);

endmodule

// File: tb/tb_div.sv
// Directed bench for div: table of vectors plus flush/reset/ignored-start sequences.
module tb_div;

    localparam int DW = 32;

    logic            clk;
    logic            resetn;
    logic            flush;
    logic            flush_cause;
    logic            start;
    logic            s;
    logic [DW-1:0]   x;
    logic [DW-1:0]   y;
    logic [2*DW-1:0] z;
    logic            ready;
    logic            busy;

    int checks;
    int errors;

    div #(.DW(DW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .flush_cause (flush_cause),
        .start       (start),
        .s           (s),
        .x           (x),
        .y           (y),
        .z           (z),
        .ready       (ready),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            s;
        logic [DW-1:0]   x;
        logic [DW-1:0]   y;
        logic [2*DW-1:0] z;
        int              lat;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start and wait (bounded) for ready; called just after a posedge.
    task automatic run_div(input logic sv, input logic [DW-1:0] xv, input logic [DW-1:0] yv,
                           output int lat, output int bcnt, output logic [2*DW-1:0] zv);
        s = sv; x = xv; y = yv; start = 1'b1;
        tick();
        start = 1'b0;
        bcnt = busy ? 1 : 0;
        lat = -1;
        zv = 'x;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (ready) begin
                lat = i;
                zv = z;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic count_ready(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (ready) cnt++;
        end
    endtask

    int lat, bcnt, nrdy;
    logic [2*DW-1:0] zv;
    logic [2*DW-1:0] zprev;

    initial begin
        checks = 0;
        errors = 0;
        resetn = 1'b0; flush = 1'b0; flush_cause = 1'b0;
        start = 1'b0; s = 1'b0; x = '0; y = '0;

        vecs[0]  = '{1'b0, 32'd100,       32'd7,          64'h00000002_0000000E, 33};
        vecs[1]  = '{1'b1, 32'hFFFFFFF9,  32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
        vecs[2]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF,   64'h00000000_80000000, 33};
        vecs[3]  = '{1'b0, 32'd5,         32'd0,          64'h00000000_00000000, 2};
        vecs[4]  = '{1'b0, 32'd9,         32'd3,          64'h00000000_00000003, 33};
        vecs[5]  = '{1'b1, 32'd7,         32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
        vecs[6]  = '{1'b0, 32'hFFFFFFFF,  32'd1,          64'h00000000_FFFFFFFF, 33};
        vecs[7]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,   64'h00000000_00000001, 33};
        vecs[8]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33};
        vecs[9]  = '{1'b1, 32'hFFFFFFF9,  32'd0,          64'h00000000_00000000, 2};
        vecs[10] = '{1'b0, 32'd3,         32'd10,         64'h00000003_00000000, 33};
        vecs[11] = '{1'b0, 32'hFFFFFFF9,  32'd2,          64'h00000001_7FFFFFFC, 33};

        #2;
        chk("reset_z", z, '0);
        chk("reset_ready", {63'd0, ready}, 64'd0);
        chk("reset_busy", {63'd0, busy}, 64'd0);
        #20;
        resetn = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            run_div(vecs[i].s, vecs[i].x, vecs[i].y, lat, bcnt, zv);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            chk($sformatf("vec%0d_z", i), zv, vecs[i].z);
            chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'(vecs[i].lat - 1));
            tick();
            chk($sformatf("vec%0d_ready_one_cycle", i), {63'd0, ready}, 64'd0);
            chk($sformatf("vec%0d_z_hold", i), z, vecs[i].z);
        end

        // Exception flush on ON cycle 10
        zprev = z;
        s = 1'b0; x = 32'd100; y = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("flush_busy_before", {63'd0, busy}, 64'd1);
        flush = 1'b1; flush_cause = 1'b1;
        tick();
        flush = 1'b0; flush_cause = 1'b0;
        chk("flush_busy_after", {63'd0, busy}, 64'd0);
        count_ready(40, nrdy);
        chk("flush_no_ready", 64'(nrdy), 64'd0);
        chk("flush_z_hold", z, zprev);
        run_div(1'b0, 32'd9, 32'd3, lat, bcnt, zv);
        chk("post_flush_z", zv, 64'h00000000_00000003);
        chk("post_flush_latency", 64'(lat), 64'd33);
        tick();

        // Non-exception flush is ignored
        flush = 1'b1; flush_cause = 1'b0;
        run_div(1'b0, 32'd100, 32'd7, lat, bcnt, zv);
        flush = 1'b0;
        chk("flush_cause0_z", zv, 64'h00000002_0000000E);
        chk("flush_cause0_latency", 64'(lat), 64'd33);
        tick();

        // Flush coincident with start in FREE drops the request
        flush = 1'b1; flush_cause = 1'b1; start = 1'b1; s = 1'b0; x = 32'd9; y = 32'd3;
        tick();
        flush = 1'b0; flush_cause = 1'b0; start = 1'b0;
        chk("flush_start_busy", {63'd0, busy}, 64'd0);
        count_ready(40, nrdy);
        chk("flush_start_no_ready", 64'(nrdy), 64'd0);

        // Start pulses while busy are ignored
        s = 1'b0; x = 32'd100; y = 32'd7; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        s = 1'b1; x = 32'd9; y = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        x = 32'd0; y = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        nrdy = 0;
        zv = '0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (ready) begin
                nrdy++;
                zv = z;
            end
        end
        chk("ignored_start_ready_count", 64'(nrdy), 64'd1);
        chk("ignored_start_z", zv, 64'h00000002_0000000E);

        // Asynchronous reset on ON cycle 5
        s = 1'b1; x = 32'hFFFFFFF9; y = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        resetn = 1'b0;
        #1;
        chk("midreset_z", z, '0);
        chk("midreset_busy", {63'd0, busy}, 64'd0);
        chk("midreset_ready", {63'd0, ready}, 64'd0);
        tick();
        resetn = 1'b1;
        count_ready(40, nrdy);
        chk("midreset_no_ready", 64'(nrdy), 64'd0);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, lat, bcnt, zv);
        chk("post_reset_z", zv, 64'hFFFFFFFF_FFFFFFFD);
        chk("post_reset_latency", 64'(lat), 64'd33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
